// File: rtl/instruction_sequencer.sv
// Fetch/decode/broadcast front-end for the cellular array: owns the PC, the
// hardware return stack and the per-instruction execution strobe.
module instruction_sequencer #(
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_WIDTH = 12,
  parameter int unsigned SP_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  output logic [15:0]         instruction,
  output logic [PC_WIDTH-1:0] next_program_counter,
  output logic [SP_WIDTH-1:0] next_stack_pointer,
  output logic                execution_enable,
  input  logic                diverge_consensus,
  output logic                busy,
  output logic                halted,
  output logic                stack_error
);

  localparam int unsigned DEPTH = (1 << SP_WIDTH) - 1;
  localparam logic [SP_WIDTH-1:0] SP_FULL = '1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, EXEC, HALT} state_t;

  state_t                state, state_next;
  logic [PC_WIDTH-1:0]   pc;
  logic [SP_WIDTH-1:0]   sp;
  logic [15:0]           instr_q;
  logic                  cons_flag;
  logic                  err_q;
  logic [PC_WIDTH-1:0]   stack [DEPTH];

  logic [3:0]            opcode;
  logic [PC_WIDTH-1:0]   target;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [SP_WIDTH-1:0]   sp_dec;
  logic                  is_halt, is_call, is_ret, fault;
  logic [PC_WIDTH-1:0]   npc;
  logic [SP_WIDTH-1:0]   nsp;
  logic                  exec_en;

  assign opcode  = instr_q[15:12];
  assign target  = PC_WIDTH'(instr_q[11:0]);
  assign pc_inc  = pc + 1'b1;
  assign sp_dec  = sp - 1'b1;
  assign is_halt = (instr_q == '0);
  assign is_call = (opcode == 4'hE);
  assign is_ret  = (opcode == 4'hF);
  assign fault   = (is_call && sp == SP_FULL) || (is_ret && sp == '0);
  assign exec_en = (state == EXEC) && !is_halt && !fault;

  // Next PC/SP come from registered state only; HALT and stack faults report
  // the current PC/SP since neither is advanced.
  always_comb begin
    npc = pc_inc;
    nsp = sp;
    if (is_halt || fault) begin
      npc = pc;
    end else begin
      case (opcode)
        4'hC: npc = target;
        4'hD: if (cons_flag) npc = target;
        4'hE: begin
          npc = target;
          nsp = sp + 1'b1;
        end
        4'hF: begin
          npc = stack[sp_dec];
          nsp = sp_dec;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, HALT: if (start) state_next = FETCH;
      FETCH:      state_next = LOAD;
      LOAD:       state_next = EXEC;
      EXEC:       state_next = (is_halt || fault) ? HALT : FETCH;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      sp        <= '0;
      instr_q   <= '0;
      cons_flag <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc        <= PC_WIDTH'(RESET_PC);
            sp        <= '0;
            cons_flag <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        LOAD: instr_q <= imem_data;
        EXEC: begin
          cons_flag <= diverge_consensus;
          if (exec_en) begin
            pc <= npc;
            sp <= nsp;
          end
          if (fault) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stack contents are not reset; sp bounds every read that matters.
  always_ff @(posedge clk) begin
    if (exec_en && is_call) stack[sp] <= pc_inc;
  end

  assign imem_addr            = pc;
  assign instruction          = instr_q;
  assign next_program_counter = npc;
  assign next_stack_pointer   = nsp;
  assign execution_enable     = exec_en;
  assign busy                 = (state == FETCH) || (state == LOAD) || (state == EXEC);
  assign halted               = (state == HALT);
  assign stack_error          = err_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: an ISA-level model (queue stack, array
// memory) predicts every broadcast; directed scenarios plus random programs.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] imem_addr;
  logic [15:0] imem_data = '0;
  logic [15:0] instruction;
  logic [11:0] next_program_counter;
  logic [4:0]  next_stack_pointer;
  logic        execution_enable;
  logic        diverge_consensus = 1'b0;
  logic        busy;
  logic        halted;
  logic        stack_error;

  always #5 clk = ~clk;

  instruction_sequencer #(
    .RESET_PC(0),
    .PC_WIDTH(12),
    .SP_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .instruction(instruction),
    .next_program_counter(next_program_counter),
    .next_stack_pointer(next_stack_pointer),
    .execution_enable(execution_enable),
    .diverge_consensus(diverge_consensus),
    .busy(busy),
    .halted(halted),
    .stack_error(stack_error)
  );

  logic [15:0] mem [4096];
  always @(posedge clk) imem_data <= mem[imem_addr];

  // ISA-level reference state
  logic [11:0] m_pc;
  logic [11:0] m_stack [$];
  bit          m_cons, m_err, m_halt;
  int          cons_mode;      // 0/1 = forced consensus, 2 = random
  bit          inject_start;   // pulse start during LOAD
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    start = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    m_pc = 12'd0;
    m_stack.delete();
    m_cons = 1'b0;
    m_err = 1'b0;
    m_halt = 1'b0;
  endtask

  // One instruction: entered in FETCH, leaves in the following FETCH or HALT.
  task automatic run_instr;
    logic [15:0] ins;
    logic [3:0]  op;
    logic [11:0] tgt, inc, e_npc;
    bit          e_en, fault, c;
    n_cmp++;
    if (imem_addr !== m_pc || busy !== 1'b1 || halted !== 1'b0 || execution_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch: addr=%h busy=%b halted=%b en=%b, expected addr=%h busy=1 halted=0 en=0",
               imem_addr, busy, halted, execution_enable, m_pc);
    end
    c = (cons_mode == 2) ? 1'($urandom_range(0, 1)) : (cons_mode == 1);
    diverge_consensus = c;
    tick;
    if (inject_start) start = 1'b1;
    n_cmp++;
    if (busy !== 1'b1 || execution_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL load: busy=%b en=%b, expected busy=1 en=0", busy, execution_enable);
    end
    tick;
    start = 1'b0;
    ins   = mem[m_pc];
    op    = ins[15:12];
    tgt   = ins[11:0];
    inc   = m_pc + 12'd1;
    fault = (op == 4'hE && m_stack.size() == 31) || (op == 4'hF && m_stack.size() == 0);
    e_en  = (ins != 16'h0000) && !fault;
    n_cmp++;
    if (instruction !== ins || execution_enable !== e_en || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL exec: instr=%h en=%b busy=%b, expected instr=%h en=%b busy=1",
               instruction, execution_enable, busy, ins, e_en);
    end
    if (e_en) begin
      e_npc = inc;
      case (op)
        4'hC: e_npc = tgt;
        4'hD: if (m_cons) e_npc = tgt;
        4'hE: begin
          m_stack.push_back(inc);
          e_npc = tgt;
        end
        4'hF: e_npc = m_stack.pop_back();
        default: ;
      endcase
      n_cmp++;
      if (next_program_counter !== e_npc || next_stack_pointer !== 5'(m_stack.size())) begin
        n_bad++;
        $display("FAIL next_pc_sp: pc=%h sp=%0d, expected pc=%h sp=%0d (instr %h at %h)",
                 next_program_counter, next_stack_pointer, e_npc, m_stack.size(), ins, m_pc);
      end
      m_pc = e_npc;
    end else begin
      m_halt = 1'b1;
      if (fault) begin
        m_err = 1'b1;
        n_cmp++;
        if (next_stack_pointer !== 5'(m_stack.size())) begin
          n_bad++;
          $display("FAIL fault_sp: sp=%0d, expected %0d", next_stack_pointer, m_stack.size());
        end
      end
    end
    m_cons = c;
    tick;
    n_cmp++;
    if (halted !== m_halt || busy !== !m_halt || execution_enable !== 1'b0 || stack_error !== m_err) begin
      n_bad++;
      $display("FAIL post_exec: halted=%b busy=%b en=%b err=%b, expected halted=%b busy=%b en=0 err=%b",
               halted, busy, execution_enable, stack_error, m_halt, !m_halt, m_err);
    end
  endtask

  task automatic run_program(input int max_instr);
    pulse_start;
    for (int i = 0; i < max_instr && !m_halt; i++) run_instr;
    if (!m_halt) do_reset;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++;
    if (imem_addr !== 0 || instruction !== 0 || next_program_counter !== 0 || next_stack_pointer !== 0 ||
        execution_enable !== 0 || busy !== 0 || halted !== 0 || stack_error !== 0) begin
      n_bad++;
      $display("FAIL reset: addr=%h ins=%h npc=%h nsp=%h en=%b busy=%b halted=%b err=%b, expected all 0",
               imem_addr, instruction, next_program_counter, next_stack_pointer,
               execution_enable, busy, halted, stack_error);
    end
  endtask

  task automatic test_basic;
    clear_mem;
    mem[0] = 16'h1234;
    cons_mode = 0;
    run_program(4);
    tick;
    n_cmp++;
    if (halted !== 1'b1 || execution_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_hold: halted=%b en=%b, expected 1/0", halted, execution_enable);
    end
  endtask

  task automatic test_jmp_wrap;
    clear_mem;
    mem[0]    = 16'hC005;
    mem[5]    = 16'hCFFF;
    mem[4095] = 16'h1111;
    cons_mode = 0;
    run_program(4);
  endtask

  task automatic test_call_ret;
    clear_mem;
    mem[0]     = 16'h1000;
    mem[1]     = 16'h2000;
    mem[2]     = 16'hE010;
    mem[12'h010] = 16'hF000;
    cons_mode = 2;
    run_program(8);
  endtask

  task automatic test_brc;
    clear_mem;
    mem[0]       = 16'h3000;
    mem[1]       = 16'hD020;
    mem[2]       = 16'h4000;
    mem[12'h020] = 16'h5000;
    cons_mode = 1;
    run_program(6);
    cons_mode = 0;
    run_program(6);
  endtask

  task automatic test_stack_faults;
    clear_mem;
    for (int i = 0; i < 32; i++) mem[i] = 16'hE000 | 16'(i + 1);
    cons_mode = 2;
    run_program(40);
    clear_mem;
    mem[0] = 16'hF000;
    run_program(4);
    pulse_start;
    n_cmp++;
    if (stack_error !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL start_clears_err: err=%b busy=%b, expected 0/1", stack_error, busy);
    end
    run_instr;
  endtask

  task automatic test_start_in_load;
    clear_mem;
    mem[0] = 16'h1234;
    mem[1] = 16'hC004;
    mem[4] = 16'h5678;
    cons_mode = 0;
    inject_start = 1'b1;
    run_program(6);
    inject_start = 1'b0;
  endtask

  task automatic test_rst_in_exec;
    bit seen;
    clear_mem;
    mem[0] = 16'h1234;
    pulse_start;
    tick;
    tick;
    n_cmp++;
    if (execution_enable !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_rst_exec: en=%b, expected 1", execution_enable);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++;
    if (imem_addr !== 0 || instruction !== 0 || next_program_counter !== 0 || next_stack_pointer !== 0 ||
        execution_enable !== 0 || busy !== 0 || halted !== 0 || stack_error !== 0) begin
      n_bad++;
      $display("FAIL rst_in_exec: addr=%h ins=%h npc=%h nsp=%h en=%b busy=%b halted=%b err=%b, expected all 0",
               imem_addr, instruction, next_program_counter, next_stack_pointer,
               execution_enable, busy, halted, stack_error);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (execution_enable !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL idle_after_rst: activity seen=1, expected 0");
    end
  endtask

  task automatic test_random;
    int r;
    for (int p = 0; p < 20; p++) begin
      clear_mem;
      for (int a = 0; a < 64; a++) begin
        r = $urandom_range(0, 15);
        case (r)
          0:       mem[a] = 16'h0000;
          1, 2:    mem[a] = 16'hC000 | 16'($urandom_range(0, 63));
          3, 4:    mem[a] = 16'hD000 | 16'($urandom_range(0, 63));
          5, 6:    mem[a] = 16'hE000 | 16'($urandom_range(0, 63));
          7, 8:    mem[a] = 16'hF000;
          default: mem[a] = {4'($urandom_range(1, 11)), 12'($urandom)};
        endcase
      end
      cons_mode = 2;
      run_program(80);
    end
  endtask

  initial begin
    cons_mode = 0;
    inject_start = 1'b0;
    clear_mem;
    test_reset;
    test_basic;
    test_jmp_wrap;
    test_call_ret;
    test_brc;
    test_stack_faults;
    test_start_in_load;
    test_rst_in_exec;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
